// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Pipelined immediate-extension unit for the decode stage. It selects one of
//   three low-aligned immediate fields and zero- or sign-extends it to DATA_W.
//   The result is registered, so there is one cycle of latency. A valid/ready
//   handshake with a 2-entry skid buffer (main + skid) lets decode and execute
//   stall independently.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   upstream request valid
//   in_ready   out  unit can accept a request this cycle
//   imm_src    in   field select: 0=F0, 1=F1, 2=F2, 3=illegal (extends to 0)
//   sign_en    in   1 = sign-extend, 0 = zero-extend
//   imm        in   raw immediate
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   result     out  extended immediate
//
// Optional feature, enabled by defining IMM_EXTEND_ERR_EN:
//   err_illegal out  main entry was accepted with imm_src=3
//   err_count   out  saturating count of illegal entries popped
module imm_extend_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 24,
    parameter int unsigned F0_W   = 10,
    parameter int unsigned F1_W   = 12,
    parameter int unsigned F2_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        imm_src,
    input  logic              sign_en,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef IMM_EXTEND_ERR_EN
    output logic              err_illegal,
    output logic [7:0]        err_count,
`endif
    output logic [DATA_W-1:0] result
);

    localparam int unsigned MIN_W = (IMM_W < DATA_W) ? IMM_W : DATA_W;

    if (F0_W < 1 || F0_W > MIN_W) begin : g_bad_f0
        $error("imm_extend_pipe: F0_W out of range");
    end
    if (F1_W < 1 || F1_W > MIN_W) begin : g_bad_f1
        $error("imm_extend_pipe: F1_W out of range");
    end
    if (F2_W < 1 || F2_W > MIN_W) begin : g_bad_f2
        $error("imm_extend_pipe: F2_W out of range");
    end

    // Mask-based extension keeps one function for every field width,
    // including a field that fills all of DATA_W (shift yields mask of all ones).
    function automatic logic [DATA_W-1:0] extend_field(
        input logic [IMM_W-1:0] raw,
        input int unsigned      w,
        input logic             sgn
    );
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] low;
        mask = (DATA_W'(1) << w) - DATA_W'(1);
        low  = DATA_W'(raw) & mask;
        return (sgn && raw[w-1]) ? (low | ~mask) : low;
    endfunction

    logic [DATA_W-1:0] ext;
    logic              ext_ill;
    logic              accept;
    logic              pop;

    logic              main_v;
    logic [DATA_W-1:0] main_data;
    logic              skid_v;
    logic [DATA_W-1:0] skid_data;

    always_comb begin
        ext     = '0;
        ext_ill = 1'b0;
        case (imm_src)
            2'd0:    ext = extend_field(imm, F0_W, sign_en);
            2'd1:    ext = extend_field(imm, F1_W, sign_en);
            2'd2:    ext = extend_field(imm, F2_W, sign_en);
            default: ext_ill = 1'b1;
        endcase
    end

    assign in_ready  = ~skid_v & ~rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = main_v;
    assign pop       = out_valid & out_ready;
    assign result    = main_data;

`ifdef IMM_EXTEND_ERR_EN
    logic main_ill;
    logic skid_ill;
    assign err_illegal = main_v & main_ill;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v    <= 1'b0;
            main_data <= '0;
            skid_v    <= 1'b0;
            skid_data <= '0;
`ifdef IMM_EXTEND_ERR_EN
            main_ill  <= 1'b0;
            skid_ill  <= 1'b0;
            err_count <= '0;
`endif
        end else begin
            if (pop || !main_v) begin
                if (skid_v) begin
                    main_data <= skid_data;
                    main_v    <= 1'b1;
                    skid_v    <= 1'b0;
`ifdef IMM_EXTEND_ERR_EN
                    main_ill  <= skid_ill;
`endif
                    if (accept) begin
                        skid_data <= ext;
                        skid_v    <= 1'b1;
`ifdef IMM_EXTEND_ERR_EN
                        skid_ill  <= ext_ill;
`endif
                    end
                end else if (accept) begin
                    main_data <= ext;
                    main_v    <= 1'b1;
`ifdef IMM_EXTEND_ERR_EN
                    main_ill  <= ext_ill;
`endif
                end else begin
                    main_v <= 1'b0;
                end
            end else if (accept) begin
                skid_data <= ext;
                skid_v    <= 1'b1;
`ifdef IMM_EXTEND_ERR_EN
                skid_ill  <= ext_ill;
`endif
            end
`ifdef IMM_EXTEND_ERR_EN
            if (pop && main_ill && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
`endif
        end
    end

`ifndef IMM_EXTEND_ERR_EN
    // The illegal flag is only consumed by the optional error outputs.
    logic unused_ill;
    assign unused_ill = ext_ill;
`endif

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the decode stage.
- Selects one of three immediate fields from the instruction immediate and extends it to DATA_W, zero- or sign-extended.
- Has a 1-cycle registered output and a valid/ready handshake with a 2-entry skid buffer, so decode and execute stall independently.
- Replaces the combinational extender in the decode path.

Parameters:
- DATA_W, 32, width of extended result.
- IMM_W, 24, width of raw immediate input.
- F0_W, 10, width of field 0 (imm[F0_W-1:0]).
- F1_W, 12, width of field 1 (imm[F1_W-1:0]).
- F2_W, 20, width of field 2 (imm[F2_W-1:0]).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  unit can accept a request this cycle.
- imm_src  input  2  field select: 0=F0, 1=F1, 2=F2, 3=illegal.
- sign_en  input  1  1 = sign-extend, 0 = zero-extend.
- imm  input  IMM_W  raw immediate.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  DATA_W  extended immediate.

Behaviour:
- Reset: clk and rst as above; rst is synchronous, active-high. On a cycle with rst=1:
  - main_v=0, skid_v=0.
  - result=0, out_valid=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-transfer discards both entries; no result is emitted for them.
- Elaboration checks: F0_W, F1_W and F2_W must each be in 1..min(IMM_W, DATA_W). Violation is an elaboration error.
- Extension (combinational, before the register):
  - Select field k from imm_src; take imm[Fk_W-1:0].
  - Upper DATA_W-Fk_W bits are all 0 when sign_en=0, or copies of imm[Fk_W-1] when sign_en=1.
  - imm_src=3 gives ext=0 regardless of sign_en.
- Handshake:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = ~skid_v & ~rst.
  - out_valid = main_v.
  - result = main_data.
  - Input-side signals are sampled only on accept; they are don't-care otherwise.
- Register update, each cycle when not in reset:
  - If pop or ~main_v:
    - if skid_v: main_data ← skid_data, main_v ← 1, skid_v ← 0; also, if accept, skid_data ← ext, skid_v ← 1. (Unreachable in practice, since in_ready=0 whenever skid_v=1.)
    - else if accept: main_data ← ext, main_v ← 1.
    - else: main_v ← 0.
  - Else (main held, no pop): if accept, skid_data ← ext, skid_v ← 1.
- Latency and throughput:
  - 1 cycle from accept to out_valid when empty.
  - Full throughput of 1 result/cycle under continuous out_ready=1.
- Ordering: results leave in acceptance order; none dropped or duplicated.
- Boundary cases:
  - Full (main_v & skid_v): in_ready=0.
  - Simultaneous pop and accept with skid empty: main is replaced by the new result the same edge; out_valid stays 1.
  - out_ready=1 while out_valid=0: no effect.
  - While out_valid=1 and out_ready=0, result and out_valid hold stable.

Optional Feature:
- Macro: IMM_EXTEND_ERR_EN.
- When defined, two extra ports:
  - err_illegal, output, 1: high alongside out_valid when the entry in main was accepted with imm_src=3. An illegal flag bit is carried per entry through main and skid.
  - err_count, output, 8: saturating count (stops at 255) of illegal entries popped. Reset 0; increments on pop of an illegal entry.
- When undefined: ports, flag bits and counter are absent; imm_src=3 still yields result=0 silently.

Test Plan:
- Zero vs sign extension, out_ready=1:
  - imm_src=0, imm=24'h0003FF, sign_en=0 → result=32'h000003FF one cycle later.
  - Same with sign_en=1 → 32'hFFFFFFFF.
- Field widths:
  - imm_src=1, imm=24'hABC800, sign_en=1 → 32'hFFFFF800.
  - imm_src=2, imm=24'h0F0001, sign_en=0 → 32'h000F0001.
  - imm_src=2, imm=24'h080000, sign_en=1 → 32'hFFF80000.
- Backpressure:
  - Hold out_ready=0; offer A=0x001, B=0x002, C=0x003 (src=0, zero-ext) back-to-back.
  - A and B accepted; in_ready=0 from the cycle after B is accepted; C is held.
  - Raise out_ready → outputs 0x1, 0x2, 0x3 in order on consecutive cycles; no loss.
- Streaming: 16 back-to-back requests with out_ready=1 → 16 results on 16 consecutive cycles after 1-cycle latency; in_ready stays 1.
- Reset mid-operation: fill both entries, assert rst for 1 cycle → out_valid=0 and result=0 at the next edge; no stale result afterwards; in_ready=1 the cycle after rst drops.
- Illegal select with IMM_EXTEND_ERR_EN defined: imm_src=3, imm=24'hFFFFFF → result=0, err_illegal=1; err_count goes 0→1 on pop. 256 illegal pops leave err_count=255.
